// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: FSM state encoding, oversample factor and width helpers.
package uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int unsigned OVERSAMPLE = 16;

  // Ceiling log2; clog2(1) = 0, callers clamp widths to at least one bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(value)) result = 32'(i + 1);
    end
    return result;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: one-cycle o_tick every DIV clocks, phase reset by i_clear.
module uart_baud_gen
  import uart_tx_pkg::*;
#(
  parameter int unsigned DIV = 1
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  output logic o_tick
);

  localparam int unsigned CW = (DIV > 1) ? clog2(DIV) : 1;

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt + CW'(1);
    if (i_clear || (cnt == CW'(DIV - 1))) cnt_next = '0;
  end

  // Tick is registered one cycle early so the consumer sees it on the DIV-th edge after clear.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      cnt    <= '0;
      o_tick <= 1'b0;
    end else begin
      cnt    <= cnt_next;
      o_tick <= (cnt_next == CW'(DIV - 1));
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1-style UART transmitter, LSB first, with busy flag and one-cycle done pulse.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD_RATE = 9600,
  parameter int unsigned NB_DATA   = 8,
  parameter int unsigned SB_TICK   = 16
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_tx_start,
  input  logic [NB_DATA-1:0] i_tx_data,
  output logic               o_tx,
  output logic               o_tx_busy,
  output logic               o_tx_done
);

  localparam int unsigned DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int unsigned OW  = clog2(max_u(OVERSAMPLE, SB_TICK));
  localparam int unsigned IW  = (NB_DATA > 1) ? clog2(NB_DATA) : 1;

  if (DIV < 1) begin : g_div_check
    $error("uart_tx: CLK_FREQ too low for BAUD_RATE*16 (DIV < 1)");
  end

  state_t             state;
  logic [OW-1:0]      os_cnt;
  logic [IW-1:0]      idx;
  logic [NB_DATA-1:0] shreg;
  logic [NB_DATA-1:0] shreg_shift;
  logic               tick;
  logic               accept;
  logic               bit_last;
  logic               stop_last;

  assign accept      = (state == IDLE) && i_tx_start;
  assign shreg_shift = shreg >> 1;
  assign bit_last    = (os_cnt == OW'(OVERSAMPLE - 1));
  assign stop_last   = (os_cnt == OW'(SB_TICK - 1));

  uart_baud_gen #(
    .DIV (DIV)
  ) u_baud_gen (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_clear (accept),
    .o_tick  (tick)
  );

  // Frame sequencer; o_tx, busy and done are all driven from registers here.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state     <= IDLE;
      os_cnt    <= '0;
      idx       <= '0;
      shreg     <= '0;
      o_tx      <= 1'b1;
      o_tx_busy <= 1'b0;
      o_tx_done <= 1'b0;
    end else begin
      o_tx_done <= 1'b0;
      case (state)
        IDLE: begin
          o_tx      <= 1'b1;
          o_tx_busy <= 1'b0;
          if (i_tx_start) begin
            shreg     <= i_tx_data;
            os_cnt    <= '0;
            idx       <= '0;
            o_tx      <= 1'b0;
            o_tx_busy <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          if (tick) begin
            if (bit_last) begin
              os_cnt <= '0;
              idx    <= '0;
              o_tx   <= shreg[0];
              state  <= DATA;
            end else begin
              os_cnt <= os_cnt + OW'(1);
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_last) begin
              os_cnt <= '0;
              if (idx == IW'(NB_DATA - 1)) begin
                idx   <= '0;
                o_tx  <= 1'b1;
                state <= STOP;
              end else begin
                idx   <= idx + IW'(1);
                shreg <= shreg_shift;
                o_tx  <= shreg_shift[0];
              end
            end else begin
              os_cnt <= os_cnt + OW'(1);
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (stop_last) begin
              os_cnt    <= '0;
              o_tx      <= 1'b1;
              o_tx_busy <= 1'b0;
              o_tx_done <= 1'b1;
              state     <= IDLE;
            end else begin
              os_cnt <= os_cnt + OW'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          o_tx  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: table-driven and random frames against a bit-timing model.
module tb_uart_tx;

  localparam int unsigned DIV      = 10;
  localparam int unsigned BIT_CLKS = 16 * DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start1 = 1'b0;
  logic [7:0] data1 = 8'h00;
  logic       tx1, busy1, done1;
  logic       start2 = 1'b0;
  logic [7:0] data2 = 8'h00;
  logic       tx2, busy2, done2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  uart_tx #(
    .CLK_FREQ (1_600_000), .BAUD_RATE (10_000), .NB_DATA (8), .SB_TICK (16)
  ) dut (
    .i_clock (clk), .i_reset (rst_n), .i_tx_start (start1), .i_tx_data (data1),
    .o_tx (tx1), .o_tx_busy (busy1), .o_tx_done (done1)
  );

  uart_tx #(
    .CLK_FREQ (1_600_000), .BAUD_RATE (10_000), .NB_DATA (8), .SB_TICK (32)
  ) dut2 (
    .i_clock (clk), .i_reset (rst_n), .i_tx_start (start2), .i_tx_data (data2),
    .o_tx (tx2), .o_tx_busy (busy2), .o_tx_done (done2)
  );

  typedef struct {
    logic [7:0] data;
    bit         noise;
    logic [7:0] expect_byte;
  } vec_t;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Expected line level k clocks after the accepting edge: start, 8 data bits LSB first, then high.
  function automatic logic model_bit(input logic [7:0] d, input int k);
    int b;
    b = k / BIT_CLKS;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    return 1'b1;
  endfunction

  // Caller has raised start at a negedge; the next posedge accepts. Ends at the negedge of the done cycle.
  task automatic run_frame(input string name, input bit sel2, input logic [7:0] exp_byte, input bit noise);
    int sb, frame, periods, busy_bad, done_bad, b;
    int bad[11];
    logic txv, busyv, donev;
    sb       = sel2 ? 32 : 16;
    frame    = (9 * 16 + sb) * DIV;
    periods  = (9 * 16 + sb) / 16;
    busy_bad = 0;
    done_bad = 0;
    foreach (bad[i]) bad[i] = 0;
    @(posedge clk);
    @(negedge clk);
    if (sel2) start2 = 1'b0; else start1 = 1'b0;
    for (int k = 0; k < frame; k++) begin
      txv   = sel2 ? tx2 : tx1;
      busyv = sel2 ? busy2 : busy1;
      donev = sel2 ? done2 : done1;
      b = k / BIT_CLKS;
      if (txv !== model_bit(exp_byte, k)) bad[b]++;
      if (busyv !== 1'b1) busy_bad++;
      if (donev !== 1'b0) done_bad++;
      if (noise && k >= 4 * BIT_CLKS + 5 && k < 4 * BIT_CLKS + 8) begin
        if (sel2) begin start2 = 1'b1; data2 = 8'hFF; end
        else begin start1 = 1'b1; data1 = 8'hFF; end
      end else if (noise && k == 4 * BIT_CLKS + 8) begin
        if (sel2) start2 = 1'b0; else start1 = 1'b0;
      end
      @(negedge clk);
    end
    for (int p = 0; p < periods; p++)
      check($sformatf("%s_bit%0d_bad_cycles", name, p), 32'(bad[p]), 32'd0);
    check({name, "_busy_low_cycles"}, 32'(busy_bad), 32'd0);
    check({name, "_early_done"}, 32'(done_bad), 32'd0);
    check({name, "_done_at_end"}, 32'(sel2 ? done2 : done1), 32'd1);
    check({name, "_busy_at_end"}, 32'(sel2 ? busy2 : busy1), 32'd0);
    check({name, "_tx_at_end"}, 32'(sel2 ? tx2 : tx1), 32'd1);
  endtask

  initial begin
    vec_t vecs[6];
    logic [7:0] rnd;

    vecs[0] = '{8'hA5, 1'b0, 8'hA5};
    vecs[1] = '{8'hA5, 1'b1, 8'hA5};
    vecs[2] = '{8'h00, 1'b0, 8'h00};
    vecs[3] = '{8'hFF, 1'b0, 8'hFF};
    vecs[4] = '{8'h01, 1'b0, 8'h01};
    vecs[5] = '{8'h80, 1'b1, 8'h80};

    // Reset held: outputs at their idle values
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_tx", 32'(tx1), 32'd1);
      check("rst_busy", 32'(busy1), 32'd0);
      check("rst_done", 32'(done1), 32'd0);
      check("rst_tx2", 32'(tx2), 32'd1);
    end
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    check("idle_tx", 32'(tx1), 32'd1);
    check("idle_busy", 32'(busy1), 32'd0);

    foreach (vecs[i]) begin
      data1  = vecs[i].data;
      start1 = 1'b1;
      run_frame($sformatf("vec%0d", i), 1'b0, vecs[i].expect_byte, vecs[i].noise);
      @(negedge clk);
      check($sformatf("vec%0d_single_done", i), 32'(done1), 32'd0);
      repeat (3) @(negedge clk);
    end

    // Back-to-back: start in the done cycle
    data1 = 8'hA5; start1 = 1'b1;
    run_frame("b2b_first", 1'b0, 8'hA5, 1'b0);
    data1 = 8'h3C; start1 = 1'b1;
    run_frame("b2b_second", 1'b0, 8'h3C, 1'b0);
    @(negedge clk);
    check("b2b_single_done", 32'(done1), 32'd0);

    for (int r = 0; r < 4; r++) begin
      repeat ($urandom_range(0, 20)) @(negedge clk);
      rnd = 8'($urandom);
      data1 = rnd; start1 = 1'b1;
      run_frame($sformatf("rnd%0d", r), 1'b0, rnd, 1'b0);
    end

    // Reset mid-frame during data bit 3
    @(negedge clk);
    data1 = 8'hA5; start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    repeat (4 * BIT_CLKS + 20) @(negedge clk);
    check("midrst_before_busy", 32'(busy1), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_async_tx", 32'(tx1), 32'd1);
    check("midrst_async_busy", 32'(busy1), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_no_done", 32'(done1), 32'd0);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("midrst_idle_tx", 32'(tx1), 32'd1);
    data1 = 8'h5A; start1 = 1'b1;
    run_frame("after_rst", 1'b0, 8'h5A, 1'b0);

    // Two stop bits on the second instance
    @(negedge clk);
    data2 = 8'h00; start2 = 1'b1;
    run_frame("two_stop", 1'b1, 8'h00, 1'b0);
    @(negedge clk);
    check("two_stop_single_done", 32'(done2), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
